countdown_timer_bcd: RTL and testbench

- BCD minutes:seconds countdown timer for the stopwatch/timer display path.
- Counts down where the up-counting 1 s stage counts up. It loads MM:SS, decrements once per second from an internal prescaler, and emits a one-cycle borrow pulse when it reaches 00:00.
- Digit outputs drive the same 7-segment decode path used by the up-counters.

---
 rtl/countdown_timer_bcd.sv | 198 +++++++++++++++++++
 tb/tb_countdown_timer_bcd.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer_bcd.sv
// BCD MM:SS countdown timer: loads a start value, decrements once per second from an
// internal prescaler and pulses borrowOut on the edge that brings the count to 00:00.
module countdown_timer_bcd #(
  parameter int unsigned PAR_CYC_PER_SEC = 66000000,
  parameter int unsigned PAR_PRE_W       = 27
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [2:0] load_min_t,
  input  logic [3:0] load_min_o,
  input  logic [2:0] load_sec_t,
  input  logic [3:0] load_sec_o,
  input  logic       start,
  input  logic       pause,
  output logic [2:0] min_t,
  output logic [3:0] min_o,
  output logic [2:0] sec_t,
  output logic [3:0] sec_o,
  output logic       running,
  output logic       done,
  output logic       borrowOut
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [PAR_PRE_W-1:0] PRE_ZERO = {PAR_PRE_W{1'b0}};
  localparam logic [PAR_PRE_W-1:0] PRE_ONE  = PAR_PRE_W'(1);
  localparam logic [PAR_PRE_W-1:0] PRE_LAST = PAR_PRE_W'(PAR_CYC_PER_SEC - 1);

  function automatic logic [3:0] sat_ones(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [2:0] sat_tens(input logic [2:0] d);
    return (d > 3'd5) ? 3'd5 : d;
  endfunction

  logic [1:0]           state_r, state_s;
  logic [PAR_PRE_W-1:0] pre_r, pre_s;
  logic [2:0]           min_t_r, min_t_s;
  logic [3:0]           min_o_r, min_o_s;
  logic [2:0]           sec_t_r, sec_t_s;
  logic [3:0]           sec_o_r, sec_o_s;
  logic                 borrow_r, borrow_s;

  logic [2:0] dec_min_t_s;
  logic [3:0] dec_min_o_s;
  logic [2:0] dec_sec_t_s;
  logic [3:0] dec_sec_o_s;
  logic       b_sec_o_s, b_sec_t_s, b_min_o_s;
  logic       dec_zero_s, cur_zero_s, tick_s;

  // One-second decrement of the current value with a digit-by-digit borrow ripple
  always_comb begin
    dec_sec_o_s = sec_o_r;
    dec_sec_t_s = sec_t_r;
    dec_min_o_s = min_o_r;
    dec_min_t_s = min_t_r;
    b_sec_o_s   = 1'b0;
    b_sec_t_s   = 1'b0;
    b_min_o_s   = 1'b0;
    if (sec_o_r == 4'd0) begin
      dec_sec_o_s = 4'd9;
      b_sec_o_s   = 1'b1;
    end else begin
      dec_sec_o_s = sec_o_r - 4'd1;
      b_sec_o_s   = 1'b0;
    end
    if (b_sec_o_s) begin
      if (sec_t_r == 3'd0) begin
        dec_sec_t_s = 3'd5;
        b_sec_t_s   = 1'b1;
      end else begin
        dec_sec_t_s = sec_t_r - 3'd1;
        b_sec_t_s   = 1'b0;
      end
    end else begin
      dec_sec_t_s = sec_t_r;
      b_sec_t_s   = 1'b0;
    end
    if (b_sec_t_s) begin
      if (min_o_r == 4'd0) begin
        dec_min_o_s = 4'd9;
        b_min_o_s   = 1'b1;
      end else begin
        dec_min_o_s = min_o_r - 4'd1;
        b_min_o_s   = 1'b0;
      end
    end else begin
      dec_min_o_s = min_o_r;
      b_min_o_s   = 1'b0;
    end
    if (b_min_o_s) begin
      dec_min_t_s = min_t_r - 3'd1;
    end else begin
      dec_min_t_s = min_t_r;
    end
  end

  assign dec_zero_s = (dec_min_t_s == 3'd0) && (dec_min_o_s == 4'd0) &&
                      (dec_sec_t_s == 3'd0) && (dec_sec_o_s == 4'd0);
  assign cur_zero_s = (min_t_r == 3'd0) && (min_o_r == 4'd0) &&
                      (sec_t_r == 3'd0) && (sec_o_r == 4'd0);
  assign tick_s     = (state_r == ST_RUN) && (pre_r == PRE_LAST);

  // Next-state, prescaler and digit selection; load is only honoured outside RUN
  always_comb begin
    state_s  = state_r;
    pre_s    = pre_r;
    min_t_s  = min_t_r;
    min_o_s  = min_o_r;
    sec_t_s  = sec_t_r;
    sec_o_s  = sec_o_r;
    borrow_s = 1'b0;
    case (state_r)
      ST_RUN: begin
        if (tick_s) begin
          pre_s   = PRE_ZERO;
          min_t_s = dec_min_t_s;
          min_o_s = dec_min_o_s;
          sec_t_s = dec_sec_t_s;
          sec_o_s = dec_sec_o_s;
          // Expiry wins over a coincident pause
          if (dec_zero_s) begin
            state_s  = ST_DONE;
            borrow_s = 1'b1;
          end else if (pause) begin
            state_s = ST_PAUSE;
          end else begin
            state_s = ST_RUN;
          end
        end else begin
          pre_s = pre_r + PRE_ONE;
          if (pause) begin
            state_s = ST_PAUSE;
          end else begin
            state_s = ST_RUN;
          end
        end
      end
      ST_IDLE, ST_PAUSE, ST_DONE: begin
        if (load) begin
          state_s = ST_IDLE;
          pre_s   = PRE_ZERO;
          min_t_s = sat_tens(load_min_t);
          min_o_s = sat_ones(load_min_o);
          sec_t_s = sat_tens(load_sec_t);
          sec_o_s = sat_ones(load_sec_o);
        end else if (start && (state_r == ST_IDLE) && !cur_zero_s) begin
          state_s = ST_RUN;
          pre_s   = PRE_ZERO;
        end else if (start && (state_r == ST_PAUSE)) begin
          state_s = ST_RUN;
        end else begin
          state_s = state_r;
        end
      end
      default: begin
        state_s = ST_IDLE;
        pre_s   = PRE_ZERO;
      end
    endcase
  end

  // State, prescaler, digit and borrow registers with synchronous reset
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      pre_r    <= PRE_ZERO;
      min_t_r  <= 3'd0;
      min_o_r  <= 4'd0;
      sec_t_r  <= 3'd0;
      sec_o_r  <= 4'd0;
      borrow_r <= 1'b0;
    end else begin
      state_r  <= state_s;
      pre_r    <= pre_s;
      min_t_r  <= min_t_s;
      min_o_r  <= min_o_s;
      sec_t_r  <= sec_t_s;
      sec_o_r  <= sec_o_s;
      borrow_r <= borrow_s;
    end
  end

  assign min_t     = min_t_r;
  assign min_o     = min_o_r;
  assign sec_t     = sec_t_r;
  assign sec_o     = sec_o_r;
  assign borrowOut = borrow_r;
  assign running   = (state_r == ST_RUN);
  assign done      = (state_r == ST_DONE);

endmodule

// File: tb/tb_countdown_timer_bcd.sv
// Scoreboard bench for countdown_timer_bcd: a seconds-based reference model pushes the
// expected post-edge outputs; a monitor pops and compares one entry per clock edge.
module tb_countdown_timer_bcd;

  localparam int CYC = 4;

  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;
  localparam int M_DONE  = 3;

  typedef struct packed {
    logic [2:0] mt;
    logic [3:0] mo;
    logic [2:0] st;
    logic [3:0] so;
    logic       run;
    logic       dn;
    logic       bo;
  } obs_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       load = 1'b0;
  logic [2:0] load_min_t = 3'd0;
  logic [3:0] load_min_o = 4'd0;
  logic [2:0] load_sec_t = 3'd0;
  logic [3:0] load_sec_o = 4'd0;
  logic       start = 1'b0;
  logic       pause = 1'b0;
  logic [2:0] min_t;
  logic [3:0] min_o;
  logic [2:0] sec_t;
  logic [3:0] sec_o;
  logic       running;
  logic       done;
  logic       borrowOut;

  countdown_timer_bcd #(.PAR_CYC_PER_SEC(CYC), .PAR_PRE_W(3)) dut (
    .clk(clk), .reset(reset), .load(load),
    .load_min_t(load_min_t), .load_min_o(load_min_o),
    .load_sec_t(load_sec_t), .load_sec_o(load_sec_o),
    .start(start), .pause(pause),
    .min_t(min_t), .min_o(min_o), .sec_t(sec_t), .sec_o(sec_o),
    .running(running), .done(done), .borrowOut(borrowOut)
  );

  always #5 clk = ~clk;

  obs_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   edge_no = 0;

  // Reference model: remaining time in whole seconds plus cycles elapsed in the current second
  int rem = 0;
  int mstate = M_IDLE;
  int elapsed = 0;

  function automatic int sat(input int v, input int lim);
    return (v > lim) ? lim : v;
  endfunction

  task automatic step(input bit r, input bit l, input int mt, input int mo,
                      input int st, input int so, input bit s, input bit p);
    obs_t e;
    int   mins;
    int   secs;
    bit   bo;
    reset = r; load = l; start = s; pause = p;
    load_min_t = 3'(mt); load_min_o = 4'(mo);
    load_sec_t = 3'(st); load_sec_o = 4'(so);
    bo = 1'b0;
    if (r) begin
      rem = 0; mstate = M_IDLE; elapsed = 0;
    end else if (mstate == M_RUN) begin
      elapsed++;
      if (elapsed == CYC) begin
        elapsed = 0;
        rem--;
        if (rem == 0) begin
          mstate = M_DONE; bo = 1'b1;
        end else if (p) begin
          mstate = M_PAUSE;
        end
      end else if (p) begin
        mstate = M_PAUSE;
      end
    end else if (l) begin
      rem = (sat(mt, 5) * 10 + sat(mo, 9)) * 60 + sat(st, 5) * 10 + sat(so, 9);
      mstate = M_IDLE; elapsed = 0;
    end else if (s && mstate == M_IDLE && rem != 0) begin
      mstate = M_RUN; elapsed = 0;
    end else if (s && mstate == M_PAUSE) begin
      mstate = M_RUN;
    end
    mins = rem / 60;
    secs = rem % 60;
    e.mt  = 3'(mins / 10);
    e.mo  = 4'(mins % 10);
    e.st  = 3'(secs / 10);
    e.so  = 4'(secs % 10);
    e.run = (mstate == M_RUN);
    e.dn  = (mstate == M_DONE);
    e.bo  = bo;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
  endtask

  task automatic do_load(input int mt, input int mo, input int st, input int so);
    step(1'b0, 1'b1, mt, mo, st, so, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    step(1'b0, 1'b0, 0, 0, 0, 0, 1'b1, 1'b0);
  endtask

  task automatic do_pause();
    step(1'b0, 1'b0, 0, 0, 0, 0, 1'b0, 1'b1);
  endtask

  // Monitor: one observation per edge, compared against the oldest pending expectation
  initial begin
    obs_t e;
    obs_t got;
    forever begin
      @(posedge clk);
      #1;
      edge_no++;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = '{min_t, min_o, sec_t, sec_o, running, done, borrowOut};
        vectors++;
        if (got !== e) begin
          miscompares++;
          $display("FAIL outputs edge %0d: got %0d%0d:%0d%0d run=%b done=%b bo=%b, expected %0d%0d:%0d%0d run=%b done=%b bo=%b",
                   edge_no, got.mt, got.mo, got.st, got.so, got.run, got.dn, got.bo,
                   e.mt, e.mo, e.st, e.so, e.run, e.dn, e.bo);
        end
      end
    end
  end

  initial begin
    @(negedge clk);
    // Reset, then load 01:05
    step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    step(1'b1, 1'b1, 5, 9, 5, 9, 1'b1, 1'b0);
    do_load(0, 1, 0, 5);
    idle(3);
    // Full borrow chain from 01:00 down to expiry
    do_load(0, 1, 0, 0);
    do_start();
    idle(245);
    do_pause();
    do_start();
    idle(3);
    // Pause mid-second, long hold, resume with held prescaler
    do_load(0, 0, 0, 3);
    do_start();
    idle(1);
    do_pause();
    idle(10);
    do_start();
    idle(14);
    // Pause coinciding with the final tick
    do_load(0, 0, 0, 1);
    do_start();
    idle(3);
    do_pause();
    idle(3);
    // Load while running is ignored
    do_load(0, 0, 0, 5);
    do_start();
    idle(2);
    do_load(3, 3, 3, 3);
    idle(6);
    // Saturation and zero start
    do_load(0, 12, 7, 0);
    idle(1);
    do_load(7, 15, 6, 10);
    idle(1);
    do_load(0, 0, 0, 0);
    do_start();
    idle(3);
    // Reset mid-run at 00:30, then start without load
    do_load(0, 0, 3, 1);
    do_start();
    idle(5);
    step(1'b1, 1'b0, 0, 0, 0, 0, 1'b0, 1'b0);
    do_start();
    idle(3);
    // Randomized traffic biased toward short values so expiry happens often
    for (int i = 0; i < 4000; i++) begin
      bit r;
      bit l;
      bit s;
      bit p;
      int mt;
      int mo;
      int st;
      int so;
      r = ($urandom_range(0, 299) == 0);
      l = ($urandom_range(0, 23) == 0);
      s = ($urandom_range(0, 7) == 0);
      p = ($urandom_range(0, 19) == 0);
      if ($urandom_range(0, 1) == 0) begin
        mt = 0; mo = 0; st = $urandom_range(0, 1); so = $urandom_range(0, 15);
      end else begin
        mt = $urandom_range(0, 7); mo = $urandom_range(0, 15);
        st = $urandom_range(0, 7); so = $urandom_range(0, 15);
      end
      step(r, l, mt, mo, st, so, s, p);
    end
    idle(2);
    @(posedge clk);
    #2;
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
